// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM state encoding for the ALU command sequencer.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Combinational 8-bit ALU datapath; all results are modulo 256, no carry out.
module ALU_8bit
    import alu_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result
);

    always_comb begin
        result = 8'h00;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL:  result = {a[6:0], 1'b0};
            OP_SHR:  result = {1'b0, a[7:1]};
            default: result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Serial command sequencer: latch a command, run one ALU/load cycle against the
// register file, write back, then hold the result until the consumer takes it.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int RA_W     = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_load,
    input  logic [2:0]      cmd_op,
    input  logic [RA_W-1:0] cmd_ra,
    input  logic [RA_W-1:0] cmd_rb,
    input  logic [RA_W-1:0] cmd_rd,
    input  logic [7:0]      cmd_imm,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [7:0]      rsp_data,
    output logic            rsp_zero,
    output logic [15:0]     op_count
);

    seq_state_t      state_q, state_d;
    logic            load_q, load_d;
    logic [2:0]      op_q, op_d;
    logic [RA_W-1:0] ra_q, ra_d;
    logic [RA_W-1:0] rb_q, rb_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [7:0]      imm_q, imm_d;
    logic [7:0]      regs_q [NUM_REGS];
    logic [7:0]      regs_d [NUM_REGS];
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic [15:0]     op_count_q, op_count_d;

    logic [7:0] alu_a, alu_b, alu_y, exec_result;

    // Operands come from the pre-edge register contents, so rd==ra/rb reads the old value.
    assign alu_a       = regs_q[ra_q];
    assign alu_b       = regs_q[rb_q];
    assign exec_result = load_q ? imm_q : alu_y;

    ALU_8bit u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (op_q),
        .result (alu_y)
    );

    always_comb begin
        state_d    = state_q;
        load_d     = load_q;
        op_d       = op_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        regs_d     = regs_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    load_d  = cmd_load;
                    op_d    = cmd_op;
                    ra_d    = cmd_ra;
                    rb_d    = cmd_rb;
                    rd_d    = cmd_rd;
                    imm_d   = cmd_imm;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                regs_d[rd_q] = exec_result;
                rsp_data_d   = exec_result;
                rsp_zero_d   = (exec_result == 8'h00);
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            load_q     <= 1'b0;
            op_q       <= OP_ADD;
            ra_q       <= '0;
            rb_q       <= '0;
            rd_q       <= '0;
            imm_q      <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
            rsp_data_q <= 8'h00;
            rsp_zero_q <= 1'b1;
            op_count_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            op_q       <= op_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            regs_q     <= regs_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            op_count_q <= op_count_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table plus handshake/reset/wrap sequences.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_ra, cmd_rb, cmd_rd;
    logic [7:0] cmd_imm;
    logic       rsp_valid, rsp_ready, rsp_zero;
    logic [7:0] rsp_data;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;

    alu_op_sequencer #(.NUM_REGS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rd    (cmd_rd),
        .cmd_imm   (cmd_imm),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ld;
        logic [2:0] op;
        logic [1:0] ra, rb, rd;
        logic [7:0] imm;
        logic [7:0] exp_d;
        logic       exp_z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one command at a negedge and walk it through EXEC and RESP.
    task automatic run_cmd(input vec_t v);
        int n;
        @(negedge clk);
        cmd_load = v.ld; cmd_op = v.op; cmd_ra = v.ra; cmd_rb = v.rb;
        cmd_rd = v.rd; cmd_imm = v.imm; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL %s.accept: cmd_ready never rose", v.name);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check({v.name, ".exec"}, {30'd0, cmd_ready, rsp_valid}, 32'd0);
        @(negedge clk);
        check({v.name, ".valid"}, {31'd0, rsp_valid}, 32'd1);
        check({v.name, ".data"}, {24'd0, rsp_data}, {24'd0, v.exp_d});
        check({v.name, ".zero"}, {31'd0, rsp_zero}, {31'd0, v.exp_z});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({v.name, ".idle"}, {30'd0, cmd_ready, rsp_valid}, 32'd2);
    endtask

    vec_t vecs[15];
    vec_t v;
    logic [15:0] cnt;

    initial begin
        vecs[0]  = '{"ld_r0_05",  1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0};
        vecs[1]  = '{"ld_r1_03",  1'b1, OP_XOR, 2'd0, 2'd0, 2'd1, 8'h03, 8'h03, 1'b0};
        vecs[2]  = '{"add_r2",    1'b0, OP_ADD, 2'd0, 2'd1, 2'd2, 8'hEE, 8'h08, 1'b0};
        vecs[3]  = '{"ld_r0_03",  1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0};
        vecs[4]  = '{"ld_r1_05",  1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 8'h05, 8'h05, 1'b0};
        vecs[5]  = '{"sub_r3",    1'b0, OP_SUB, 2'd0, 2'd1, 2'd3, 8'h00, 8'hFE, 1'b0};
        vecs[6]  = '{"xor_r3",    1'b0, OP_XOR, 2'd3, 2'd3, 2'd3, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{"ld_r0_81",  1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'h81, 8'h81, 1'b0};
        vecs[8]  = '{"shl_r0",    1'b0, OP_SHL, 2'd0, 2'd1, 2'd0, 8'h00, 8'h02, 1'b0};
        vecs[9]  = '{"shr_r0",    1'b0, OP_SHR, 2'd0, 2'd1, 2'd0, 8'h00, 8'h01, 1'b0};
        vecs[10] = '{"not_r0",    1'b0, OP_NOT, 2'd0, 2'd1, 2'd0, 8'h00, 8'hFE, 1'b0};
        vecs[11] = '{"and_r2",    1'b0, OP_AND, 2'd2, 2'd1, 2'd2, 8'h00, 8'h00, 1'b1};
        vecs[12] = '{"or_r2",     1'b0, OP_OR,  2'd1, 2'd0, 2'd2, 8'h00, 8'hFF, 1'b0};
        vecs[13] = '{"add_wrap",  1'b0, OP_ADD, 2'd2, 2'd1, 2'd3, 8'h00, 8'h04, 1'b0};
        vecs[14] = '{"sub_self",  1'b0, OP_SUB, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0;
        cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_rd = 2'd0; cmd_imm = 8'h00; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.rsp_data", {24'd0, rsp_data}, 32'h00);
        check("rst.rsp_zero", {31'd0, rsp_zero}, 32'd1);
        check("rst.op_count", {16'd0, op_count}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_cmd(vecs[i]);
            if (i == 2) check("op_count_after_3", {16'd0, op_count}, 32'd3);
        end
        check("op_count_after_15", {16'd0, op_count}, 32'd15);

        // Backpressure: response held 10 cycles while a new command waits.
        @(negedge clk);
        cmd_load = 1'b1; cmd_rd = 2'd2; cmd_imm = 8'h5A; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("hold.first_valid", {31'd0, rsp_valid}, 32'd1);
        cnt = op_count;
        cmd_load = 1'b0; cmd_op = OP_ADD; cmd_ra = 2'd2; cmd_rb = 2'd2; cmd_rd = 2'd3;
        cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold.rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold.rsp_data", {24'd0, rsp_data}, 32'h5A);
            check("hold.cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("hold.op_count", {16'd0, op_count}, {16'd0, cnt});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold.release", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        check("hold.count_inc", {16'd0, op_count}, {16'd0, cnt + 16'd1});
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold.pending_accepted", {30'd0, cmd_ready, rsp_valid}, 32'd0);
        @(negedge clk);
        check("hold.pending_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold.pending_data", {24'd0, rsp_data}, 32'hB4);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold.count_17", {16'd0, op_count}, 32'd17);

        // Reset lands in EXEC of "load r1=AA": the write must be lost.
        @(negedge clk);
        cmd_load = 1'b1; cmd_rd = 2'd1; cmd_imm = 8'hAA; cmd_valid = 1'b1;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstx.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstx.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rstx.op_count", {16'd0, op_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstx.rsp_zero", {31'd0, rsp_zero}, 32'd1);
        v = '{"rstx_read_r1", 1'b0, OP_OR, 2'd1, 2'd1, 2'd2, 8'h00, 8'h00, 1'b1};
        run_cmd(v);
        check("rstx.count_1", {16'd0, op_count}, 32'd1);

        // Counter wrap from 16'hFFFF.
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        check("wrap.preload", {16'd0, op_count}, 32'hFFFF);
        v = '{"wrap_cmd", 1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'h11, 8'h11, 1'b0};
        run_cmd(v);
        check("wrap.op_count", {16'd0, op_count}, 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-driven controller that sequences the 8-bit ALU (`ALU_8bit`) over a small register file. It accepts one command at a time over a valid/ready handshake, either loads an immediate or runs an ALU operation on two registers. It writes the result back, then returns the result and a zero flag over a second valid/ready handshake. It sits between a host/testbench command source and the combinational ALU datapath.

## Interface
- `NUM_REGS`, 4: register file depth; power of two, at least 2; `RA_W = $clog2(NUM_REGS)`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_load`  in  1  1 = write `cmd_imm` to `cmd_rd`; 0 = ALU op.
- `cmd_op`  in  3  ALU opcode (ignored when `cmd_load`=1).
- `cmd_ra`, `cmd_rb`  in  RA_W  source register indices (a, b).
- `cmd_rd`  in  RA_W  destination register index.
- `cmd_imm`  in  8  immediate for load.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  8  value written to `cmd_rd`.
- `rsp_zero`  out  1  `rsp_data == 8'h00`.
- `op_count`  out  16  number of completed commands (response handshakes).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch all cmd fields and go to EXEC.
- EXEC (exactly one cycle):
  - Drive the ALU with `a = regs[ra_q]`, `b = regs[rb_q]`, `op = op_q`.
  - Result is the ALU output, or `imm_q` for a load.
  - At the closing edge: write the result to `regs[rd_q]`, capture it into `rsp_data` and `rsp_zero`, then go to RESP.
- RESP:
  - `rsp_valid`=1 and `rsp_data`/`rsp_zero` held stable.
  - On `rsp_ready`, increment `op_count` and go to IDLE.
- ALU opcodes, all modulo 256:
  - 000 add, 001 sub (a-b).
  - 010 and, 011 or, 100 xor.
  - 101 not a, b ignored.
  - 110 a<<1, 111 a>>1 logical, zero fill.
- No carry/borrow is exported.
- Source equals destination (`ra==rd` or `rb==rd`): EXEC reads the old value; the write takes effect after the edge.
- Commands are strictly serialized; no hazards are possible.
- `cmd_valid` asserted outside IDLE is ignored (`cmd_ready`=0); the source must hold it.
- `op_count` wraps 16'hFFFF -> 16'h0000.

## Timing
- Reset values: state IDLE, all regs 8'h00, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=8'h00, `rsp_zero`=1, `op_count`=0.
- Command accepted at edge N: EXEC during cycle N→N+1; register write and `rsp_valid`=1 from edge N+1.
- Response accepted at edge M (`rsp_valid & rsp_ready`): `rsp_valid` falls and `cmd_ready` rises after M.
- Minimum 3 cycles per command; `rsp_ready` may be held high.
- `rsp_ready` while `rsp_valid`=0 has no effect.
- All outputs are registered or decoded from state only; no combinational path from cmd_* or `rsp_ready` to outputs.
- Reset asserted mid-operation, in any state: immediate return to reset values.
  - The in-flight command is lost.
  - A register write is suppressed if reset coincides with the EXEC edge.

## Structure
- Package `alu_seq_pkg`:
  - Opcode localparams `OP_ADD` … `OP_SHR` (3'b000–3'b111).
  - State enum `seq_state_t` {IDLE, EXEC, RESP}.
- One sub-module: instance of the existing `ALU_8bit` as the datapath.
- The register file, FSM, and counter stay in this module.

## Test plan
- Reset, then load r0=8'h05, load r1=8'h03, then add r2=r0+r1 → responses 8'h05, 8'h03, 8'h08; `rsp_zero`=0; `op_count`=3.
- With r0=8'h03 and r1=8'h05: sub r3=r0-r1 → 8'hFE; xor r3=r3^r3 → 8'h00 with `rsp_zero`=1.
- Load r0=8'h81; shl r0 → 8'h02; shr r0 → 8'h01; not r0 → 8'hFE. Each command uses r0 as both source and destination.
- Hold `rsp_ready`=0 for 10 cycles with a new `cmd_valid` pending:
  - `rsp_valid` and `rsp_data` stay stable, `cmd_ready`=0, `op_count` is unchanged.
  - After `rsp_ready`, the pending command is accepted next cycle.
- Assert `rst` in EXEC of "load r1=8'hAA" → r1 reads 8'h00 afterwards, `rsp_valid`=0, `op_count`=0.
- Preload `op_count` to 16'hFFFF via 65535 commands, or force it in sim; one more command → `op_count`=16'h0000.
